// File: rtl/jk_bank_sequencer_if.sv
// Purpose: request/status bundle between a controlling FSM, the JK sequencer and its flip-flop bank.
// Latency: wires only, no storage.
// Backpressure: none; start is honoured only while the sequencer is idle, otherwise dropped.
// Signals: start/stop/mode/steps/load_val request an operation, q_bank carries the bank state in,
//          j_out/k_out drive the bank, busy/done/wrapped report progress.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q_bank;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             wrapped;

    // Controller side: issues requests and owns the bank state.
    modport master (
        output start, stop, mode, steps, load_val, q_bank,
        input  j_out, k_out, busy, done, wrapped
    );

    // Sequencer side.
    modport slave (
        input  start, stop, mode, steps, load_val, q_bank,
        output j_out, k_out, busy, done, wrapped
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Purpose: drives J/K excitation so an external JK flip-flop bank counts up/down, rotates or loads for N edges.
// Latency: first bank update on the edge after start is accepted; done pulses the cycle after the last step.
// Backpressure: start ignored while busy or done (not queued); stop aborts a run without updating the bank.
// Ports: clk, reset (synchronous, active-high) plus bus (slave modport):
//        start/stop/mode/steps/load_val in, q_bank in, j_out/k_out out, busy/done/wrapped out.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    jk_bank_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_UP   = 2'b00;
    localparam logic [1:0]       MODE_DOWN = 2'b01;
    localparam logic [1:0]       MODE_ROTL = 2'b10;
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] BANK_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH-1:0] next_val;
    logic             wrap_step;
    logic [WIDTH-1:0] j_c, k_c;
    logic             busy_c, done_c;

    // Target value for the bank on the coming edge, from the live bank state.
    always_comb begin
        next_val  = load_q;
        wrap_step = 1'b0;
        case (mode_q)
            MODE_UP: begin
                next_val  = bus.q_bank + BANK_ONE;
                wrap_step = (bus.q_bank == ALL_ONES);
            end
            MODE_DOWN: begin
                next_val  = bus.q_bank - BANK_ONE;
                wrap_step = (bus.q_bank == '0);
            end
            MODE_ROTL: next_val = {bus.q_bank[WIDTH-2:0], bus.q_bank[WIDTH-1]};
            default:   next_val = load_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        load_d    = load_q;
        wrapped_d = wrapped_q;
        j_c       = '0;
        k_c       = '0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    load_d    = bus.load_val;
                    cnt_d     = bus.steps;
                    wrapped_d = 1'b0;
                    state_d   = (bus.steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (bus.stop) begin
                    // Abort wins over the step: J=K=0 keeps the bank where it is.
                    state_d = S_DONE;
                end else begin
                    // Set-only / reset-only excitation; J and K are never both high.
                    j_c   = next_val & ~bus.q_bank;
                    k_c   = ~next_val & bus.q_bank;
                    cnt_d = cnt_q - CNT_ONE;
                    if (wrap_step) begin
                        wrapped_d = 1'b1;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= 2'b00;
            load_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            load_q    <= load_d;
            wrapped_q <= wrapped_d;
        end
    end

    // The bank shares this reset, so excitation is forced off while reset is held
    // even though the state register only clears on the edge.
    assign bus.j_out   = reset ? '0 : j_c;
    assign bus.k_out   = reset ? '0 : k_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.wrapped = wrapped_q;
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Controller for a bank of WIDTH JK flip-flops that share its clk/reset.
- Reads the bank state `q_bank` and drives per-bit J/K excitation so the bank steps through one of four sequences (count up, count down, rotate left, load) for a programmed number of clock edges.
- Start/busy/done handshake, so a higher-level FSM or testbench can sequence register operations without computing J/K itself.

Parameters:
- WIDTH, 4, number of JK flip-flops in the controlled bank
- CNT_W, 8, width of step counter; max steps per operation = 2^CNT_W-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- stop  input  1  abort the running operation
- mode  input  2  00 count up, 01 count down, 10 rotate left, 11 load
- steps  input  CNT_W  number of bank updates; latched on start
- load_val  input  WIDTH  target value for mode 11; latched on start
- q_bank  input  WIDTH  current Q outputs of the flip-flop bank
- j_out  output  WIDTH  J inputs to bank
- k_out  output  WIDTH  K inputs to bank
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on completion or abort
- wrapped  output  1  sticky: count up passed all-ones->0 or count down passed 0->all-ones during current op

Behaviour:
- Reset: synchronous, active-high; one clock; reset is synchronous and active-high.
  - On reset edge: state=IDLE, step counter=0, latched mode/load_val=0, busy=0, done=0, wrapped=0.
  - j_out=k_out=0 while reset is asserted and in IDLE/DONE (bank holds).
  - Reset mid-RUN aborts immediately; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - j_out=k_out=0.
  - start=1 at edge: latch mode, steps, load_val; clear wrapped.
  - If steps==0 -> DONE, else -> RUN with counter=steps.
- RUN:
  - busy=1.
  - Combinationally compute next from q_bank and latched mode:
    - up: q+1 mod 2^WIDTH
    - down: q-1 mod 2^WIDTH
    - rotl: {q[WIDTH-2:0], q[WIDTH-1]}
    - load: load_val
  - Excitation per bit: j_out = next & ~q_bank; k_out = ~next & q_bank (never J=K=1).
  - Each RUN edge: bank takes next; counter decrements.
  - wrapped sets on the edge where up moves all-ones->0 or down moves 0->all-ones.
  - Mode load holds after the first step; further steps re-apply the same value.
  - counter==1 at edge -> DONE.
- stop=1 in RUN:
  - j_out=k_out=0 that cycle (bank holds).
  - -> DONE at that edge.
  - stop has priority over the step.
  - stop outside RUN is ignored.
- DONE: done=1 for exactly one cycle, busy=0, j_out=k_out=0, -> IDLE. wrapped holds until the next accepted start.
- Latency:
  - start edge to first bank update: 1 cycle.
  - N steps: busy high N cycles, done in cycle N+1 after start.
  - Earliest restart: the cycle after done.
- start while busy or in DONE is ignored (not queued).
- Inputs mode/steps/load_val changing during RUN have no effect.
- q_bank is used combinationally; the bank must update only on clk edges with the same reset.

Test Plan:
- Reset, then start with mode=00, steps=5, bank=0000 -> busy high 5 cycles, bank 1,2,3,4,5, done pulse in cycle 6, wrapped=0, J/K never both 1 on any bit.
- Bank=1110, mode=00, steps=3 -> bank 1111, 0000, 0001; wrapped=1 after the 2nd step and sticky through done; cleared on next start.
- Bank=0000, mode=01, steps=2 -> bank 1111, 1110, wrapped=1; then mode=10, steps=4 from 1001 -> 0011, 0110, 1100, 1001.
- mode=11, load_val=1010, steps=1 from 0101 -> j_out=1010, k_out=0101 for one cycle, bank=1010, done next cycle. Separately, steps=0 -> no bank change, done one cycle after start, busy never high.
- Abort: mode=00, steps=10 from 0000, assert stop at 3rd RUN cycle -> bank stays 0010, done pulses next cycle. Separately, assert reset mid-RUN -> all outputs 0 next cycle, no done. In both cases a start pulse during busy is ignored.
